// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int DEF_XLEN = 32;
  localparam logic [31:0] ZERO_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [31:0]         instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with occupancy count and single-cycle clear.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             write_s;

  assign write_s = rst & ~clear & push;

  // Entry storage; unreset because only slots below count are ever presented.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a decoupling queue and redirect squashing.
// Optional macro FETCH_QUEUE_PERF_EN adds saturating perf_fetched/perf_bubble counters.
module fetch_queue import fetch_pkg::*; #(
  parameter int              XLEN     = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000),
  parameter int              QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            ReadyD,
  output logic            ValidD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_bubble
`endif
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = XLEN + 32;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]   CNT_ZERO  = CW'(1'b0);
  localparam logic [CW:0]     DEPTH_LIM = (CW+1)'(QDEPTH);

  logic [XLEN-1:0] fetch_pc_r;
  logic [XLEN-1:0] resp_pc_r;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   stale_r;
  logic [CW-1:0]   count_s;
  logic [EW-1:0]   head_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            valid_s;

  // Queued plus outstanding entries never exceed the queue, so pushes cannot overflow.
  assign issue_s = rst & ~PCSrcE & (({1'b0, count_s} + {1'b0, inflight_r}) < DEPTH_LIM);
  assign push_s  = rst & imem_rvalid & ~PCSrcE & (stale_r == CNT_ZERO);
  assign valid_s = rst & (count_s != CNT_ZERO);
  assign pop_s   = valid_s & ReadyD & ~PCSrcE;

  fetch_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (PCSrcE),
    .push  (push_s),
    .wdata ({resp_pc_r, imem_rdata}),
    .pop   (pop_s),
    .rdata (head_s),
    .count (count_s)
  );

  // Responses return in order, so resp_pc_r tracks the PC of the next live response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= CNT_ZERO;
      stale_r    <= CNT_ZERO;
    end else begin
      if (PCSrcE) begin
        fetch_pc_r <= PCTargetE;
        resp_pc_r  <= PCTargetE;
        stale_r    <= inflight_r - (imem_rvalid ? CNT_ONE : CNT_ZERO);
      end else begin
        if (issue_s) begin
          fetch_pc_r <= fetch_pc_r + PC_STEP;
        end
        if (push_s) begin
          resp_pc_r <= resp_pc_r + PC_STEP;
        end
        if (imem_rvalid && (stale_r != CNT_ZERO)) begin
          stale_r <= stale_r - CNT_ONE;
        end
      end
      case ({issue_s, imem_rvalid})
        2'b10:   inflight_r <= inflight_r + CNT_ONE;
        2'b01:   inflight_r <= inflight_r - CNT_ONE;
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign imem_req  = issue_s;
  assign imem_addr = fetch_pc_r;
  assign ValidD    = valid_s;
  assign InstrD    = valid_s ? head_s[31:0] : ZERO_INSTR;
  assign PCD       = valid_s ? head_s[EW-1:32] : {XLEN{1'b0}};
  assign PCPlus4D  = valid_s ? (head_s[EW-1:32] + PC_STEP) : {XLEN{1'b0}};

`ifdef FETCH_QUEUE_PERF_EN
  // Saturating counts of delivered fetches and decode-starved cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= 32'h0000_0000;
      perf_bubble  <= 32'h0000_0000;
    end else begin
      if (push_s && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (ReadyD && !valid_s && (perf_bubble != 32'hFFFF_FFFF)) begin
        perf_bubble <= perf_bubble + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
